// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M multiply/divide sequencer for the execute stage.
// Runs a shift-add multiply or a restoring divide at one bit per cycle, stalls
// the pipeline while busy and returns a registered result with a done pulse.
//
// Ports:
//   clk       clock
//   reset     synchronous, active-high reset
//   valid_i   EX holds a candidate op this cycle
//   op_i      alufunc code (MUL=16 .. REMUW=25, anything else is ignored)
//   a_i, b_i  rs1 / rs2 operands
//   flush_i   pipeline flush, kills the current op
//   busy_o    stall request to hazard control
//   done_o    one-cycle pulse, result_o valid
//   result_o  final result, registered
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  // Most-negative 32-bit value after sign extension to XLEN.
  localparam logic [XLEN-1:0] MIN_H = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;

  // W results are the low half, sign-extended to XLEN.
  function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] x, input logic w);
    return w ? {{HW{x[HW-1]}}, x[HW-1:0]} : x;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  // Decode of the request
  logic is_md, is_mul, is_w, is_sgn, is_rem, accept;

  always_comb begin
    is_md  = (op_i >= 5'd16) && (op_i <= 5'd25);
    is_mul = (op_i == 5'd16) || (op_i == 5'd21);
    is_w   = (op_i >= 5'd21) && is_md;
    is_sgn = (op_i == 5'd17) || (op_i == 5'd18) || (op_i == 5'd22) || (op_i == 5'd23);
    is_rem = (op_i == 5'd18) || (op_i == 5'd20) || (op_i == 5'd23) || (op_i == 5'd25);
    accept = (state == IDLE) && valid_i && is_md && !flush_i;
  end

  // Operand preparation: width/sign extension, magnitudes, special cases
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_res;
  logic            neg_a, neg_b, div_zero, div_ovf, special;

  always_comb begin
    a_ext    = is_w ? {{HW{is_sgn & a_i[HW-1]}}, a_i[HW-1:0]} : a_i;
    b_ext    = is_w ? {{HW{is_sgn & b_i[HW-1]}}, b_i[HW-1:0]} : b_i;
    neg_a    = is_sgn & a_ext[XLEN-1];
    neg_b    = is_sgn & b_ext[XLEN-1];
    a_mag    = neg_if(a_ext, neg_a);
    b_mag    = neg_if(b_ext, neg_b);
    div_zero = (b_ext == '0);
    div_ovf  = is_sgn && (a_ext == (is_w ? MIN_H : MIN_X)) && (b_ext == '1);
    special  = !is_mul && (div_zero || div_ovf);
    if (div_zero)
      spec_res = is_rem ? fmt_w(a_ext, is_w) : '1;
    else
      spec_res = is_rem ? '0 : fmt_w(a_ext, is_w);
  end

  // Iteration datapath. acc is the product accumulator for MUL and the
  // partial remainder for DIV; opa is the shifting multiplicand or the
  // dividend/quotient register; opb is the multiplier or the divisor.
  logic [XLEN-1:0] acc, opa, opb;
  logic            w_q, rem_q, negq_q, negr_q;

  logic [XLEN-1:0] mul_acc_nx, rem_nx, q_nx, mul_res, div_res;
  logic [XLEN:0]   rem_sh, diff;
  logic            fits, last_iter;

  always_comb begin
    mul_acc_nx = acc + (opb[0] ? opa : '0);
    rem_sh     = {acc, opa[XLEN-1]};
    diff       = rem_sh - {1'b0, opb};
    fits       = !diff[XLEN];
    rem_nx     = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    q_nx       = {opa[XLEN-2:0], fits};
    mul_res    = fmt_w(mul_acc_nx, w_q);
    div_res    = fmt_w(rem_q ? neg_if(rem_nx, negr_q) : neg_if(q_nx, negq_q), w_q);
    last_iter  = (cnt == '0);
  end

  // Next-state and outputs
  always_comb begin
    state_nx = state;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          busy_o = 1'b1;
          if (is_mul)       state_nx = MUL;
          else if (special) state_nx = DONE;
          else              state_nx = DIV;
        end
      end
      MUL, DIV: begin
        busy_o = 1'b1;
        if (flush_i)        state_nx = IDLE;
        else if (last_iter) state_nx = DONE;
      end
      DONE: begin
        done_o   = !flush_i;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state, counter and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= is_w ? CW'(HW - 1) : CW'(XLEN - 1);
        if (special && !is_mul)
          result_o <= spec_res;
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt - 1'b1;
        if (last_iter && !flush_i)
          result_o <= (state == MUL) ? mul_res : div_res;
      end
    end
  end

  // Operand capture and per-iteration update
  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= '0;
      opa    <= is_mul ? a_ext : (is_w ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag);
      opb    <= is_mul ? b_ext : b_mag;
      w_q    <= is_w;
      rem_q  <= is_rem;
      negq_q <= neg_a ^ neg_b;
      negr_q <= neg_a;
    end else if (state == MUL) begin
      acc <= mul_acc_nx;
      opa <= {opa[XLEN-2:0], 1'b0};
      opb <= {1'b0, opb[XLEN-1:1]};
    end else if (state == DIV) begin
      acc <= rem_nx;
      opa <= q_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [4:0]  op_i = 5'd0;
  logic [63:0] a_i = 64'd0;
  logic [63:0] b_i = 64'd0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o;
  logic [63:0] result_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_exp = 64'd0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  muldiv_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  // Reference model: RV64M semantics from plain arithmetic.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    longint signed sa, sb;
    int signed     sa32, sb32;
    logic [31:0]   ua32, ub32, r32;
    sa = $signed(a); sb = $signed(b);
    sa32 = $signed(a[31:0]); sb32 = $signed(b[31:0]);
    ua32 = a[31:0]; ub32 = b[31:0];
    r32 = 32'd0;
    case (op)
      5'd16: return a * b;
      5'd17: if (b == 0) return '1; else if (a == MIN64 && sb == -1) return a; else return 64'(sa / sb);
      5'd18: if (b == 0) return a;  else if (a == MIN64 && sb == -1) return 64'd0; else return 64'(sa % sb);
      5'd19: if (b == 0) return '1; else return a / b;
      5'd20: if (b == 0) return a;  else return a % b;
      5'd21: r32 = ua32 * ub32;
      5'd22: if (ub32 == 0) r32 = '1; else if (ua32 == 32'h8000_0000 && sb32 == -1) r32 = ua32; else r32 = 32'(sa32 / sb32);
      5'd23: if (ub32 == 0) r32 = ua32; else if (ua32 == 32'h8000_0000 && sb32 == -1) r32 = 32'd0; else r32 = 32'(sa32 % sb32);
      5'd24: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
      5'd25: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
      default: r32 = 32'd0;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  // Cycles from accept to the done pulse.
  function automatic int exp_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, sgn, zero, ovf;
    int n;
    w = (op >= 5'd21);
    n = w ? 33 : 65;
    if (op == 5'd16 || op == 5'd21) return n;
    sgn  = (op == 5'd17) || (op == 5'd18) || (op == 5'd22) || (op == 5'd23);
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == MIN64 && b == '1));
    return (zero || ovf) ? 1 : n;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return 64'd0;
      2: return 64'd1;
      3: return '1;
      4: return ($urandom_range(0, 1) != 0) ? MIN64 : 64'hFFFF_FFFF_8000_0000;
      default: return 64'($urandom_range(0, 20));
    endcase
  endfunction

  // Issue one op from IDLE and wait (bounded) for its done pulse. Inputs are
  // scrambled right after the accept edge to show they are not re-read.
  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int bcnt,
                        output logic extra_done);
    @(negedge clk);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    bcnt = busy_o ? 1 : 0;
    @(posedge clk); #1;
    valid_i = 1'b0; op_i = 5'($urandom); a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
    lat = -1;
    res = 64'd0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done_o) begin
        lat = k;
        res = result_o;
        break;
      end
      if (busy_o) bcnt++;
    end
    @(negedge clk);
    extra_done = done_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
  endtask

  task automatic test_directed();
    logic [4:0]  d_op  [11] = '{5'd16, 5'd17, 5'd18, 5'd20, 5'd19, 5'd18, 5'd17, 5'd23, 5'd21, 5'd24, 5'd22};
    logic [63:0] d_a   [11] = '{64'd3, -64'sd7, -64'sd7, 64'd7, 64'h1234, 64'h1234, MIN64,
                                64'h8000_0000, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFF9};
    logic [63:0] d_b   [11] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0, '1,
                                64'hFFFF_FFFF, 64'd2, 64'd1, 64'd2};
    logic [63:0] d_r   [11] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd1, '1,
                                64'h1234, MIN64, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, '1,
                                64'hFFFF_FFFF_FFFF_FFFD};
    int          d_lat [11] = '{65, 65, 65, 65, 1, 1, 1, 1, 33, 33, 33};
    logic [63:0] res;
    int          lat, bcnt;
    logic        xd;
    for (int i = 0; i < 11; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, bcnt, xd);
      checks++; if (res !== d_r[i]) begin failures++; $display("FAIL dir%0d_result op=%0d got=%h exp=%h", i, d_op[i], res, d_r[i]); end
      checks++; if (lat != d_lat[i]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, d_lat[i]); end
      checks++; if (bcnt != d_lat[i]) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bcnt, d_lat[i]); end
      checks++; if (xd !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, xd); end
      last_exp = d_r[i];
    end
  endtask

  task automatic test_random();
    logic [63:0] res, a, b, e;
    logic [4:0]  op;
    int          lat, bcnt, el;
    logic        xd;
    for (int i = 0; i < 40; i++) begin
      op = 5'(16 + $urandom_range(0, 9));
      a = pick();
      b = pick();
      e = model(op, a, b);
      el = exp_lat(op, a, b);
      run_op(op, a, b, res, lat, bcnt, xd);
      checks++; if (res !== e) begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, e); end
      checks++; if (lat != el || bcnt != el) begin failures++; $display("FAIL rnd%0d_timing op=%0d lat=%0d busy=%0d exp=%0d", i, op, lat, bcnt, el); end
      last_exp = e;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a1, a2;
    a1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    @(negedge clk);
    valid_i = 1'b1; op_i = 5'd20; a_i = a1; b_i = 64'd0;
    #1;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_busy_T got=%b exp=1", busy_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL b2b_done1 done=%b busy=%b exp=1/0", done_o, busy_o); end
    checks++; if (result_o !== a1) begin failures++; $display("FAIL b2b_result1 got=%h exp=%h", result_o, a1); end
    a_i = a2;
    @(negedge clk);
    checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL b2b_bubble busy=%b done=%b exp=1/0", busy_o, done_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || result_o !== a2) begin failures++; $display("FAIL b2b_done2 done=%b got=%h exp=%h", done_o, result_o, a2); end
    valid_i = 1'b0;
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_done got=%b exp=0", done_o); end
    last_exp = a2;
  endtask

  task automatic test_flush_mid();
    logic seen_done;
    int   lat;
    logic [63:0] ma, mb, e;
    seen_done = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; op_i = 5'd17; a_i = 64'd1000; b_i = 64'd7;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_o) seen_done = 1'b1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || seen_done) begin failures++; $display("FAIL flush_abort busy=%b done=%b seen=%b exp=0/0/0", busy_o, done_o, seen_done); end
    checks++; if (result_o !== last_exp) begin failures++; $display("FAIL flush_result_hold got=%h exp=%h", result_o, last_exp); end
    ma = {$urandom, $urandom};
    mb = {$urandom, $urandom};
    e = model(5'd16, ma, mb);
    valid_i = 1'b1; op_i = 5'd16; a_i = ma; b_i = mb;
    #1;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL flush_new_accept got=%b exp=1", busy_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done_o) begin lat = k; break; end
    end
    checks++; if (lat != 65) begin failures++; $display("FAIL flush_new_latency got=%0d exp=65", lat); end
    checks++; if (result_o !== e) begin failures++; $display("FAIL flush_new_result got=%h exp=%h", result_o, e); end
    last_exp = e;
  endtask

  task automatic test_idle_cases();
    logic bad;
    @(negedge clk);
    valid_i = 1'b1; op_i = 5'd16; a_i = 64'd5; b_i = 64'd6; flush_i = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_flush_busy got=%b exp=0", busy_o); end
    @(posedge clk); #1;
    flush_i = 1'b0; op_i = 5'd0;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL non_md_op0_busy got=%b exp=0", busy_o); end
    @(posedge clk); #1;
    op_i = 5'd26;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL non_md_op26_busy got=%b exp=0", busy_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    bad = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done_o || busy_o) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL idle_no_activity got=1 exp=0"); end
  endtask

  task automatic test_flush_done();
    @(negedge clk);
    valid_i = 1'b1; op_i = 5'd19; a_i = 64'h55; b_i = 64'd0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL flush_in_done got=%b exp=0", done_o); end
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL flush_done_idle done=%b busy=%b exp=0/0", done_o, busy_o); end
  endtask

  task automatic test_reset_abort();
    logic bad;
    @(negedge clk);
    valid_i = 1'b1; op_i = 5'd17; a_i = 64'd1000; b_i = 64'd7;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", busy_o); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL rst_abort busy=%b done=%b exp=0/0", busy_o, done_o); end
    checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL rst_abort_result got=%h exp=0", result_o); end
    bad = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done_o) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL rst_abort_no_done got=1 exp=0"); end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush_mid();
    test_idle_cases();
    test_flush_done();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
